// File: rtl/spi_types_pkg.sv
// Shared types and constants for the ADS1256 command sequencer.
//   routine_t : routine selector presented with a start request
//   step_t    : which command frame the sequencer is currently driving
//   CMD_*     : ADS1256 command opcodes
//   FRAME_*   : 24-bit SPI frames {cmd, arg1, arg2}
package spi_types_pkg;

  typedef enum logic [2:0] {
    ROUTINE_NONE       = 3'd0,
    ROUTINE_CALIBRATE  = 3'd1,
    ROUTINE_READBACK   = 3'd2,
    ROUTINE_SINGLE     = 3'd3,
    ROUTINE_CONTINUOUS = 3'd4,
    ROUTINE_ILLEGAL    = 3'd5
  } routine_t;

  typedef enum logic [3:0] {
    STEP_NONE        = 4'd0,
    STEP_SELFCAL     = 4'd1,
    STEP_RREG_STATUS = 4'd2,
    STEP_SYNC        = 4'd3,
    STEP_WAKEUP      = 4'd4,
    STEP_RDATA       = 4'd5,
    STEP_RDATAC      = 4'd6,
    STEP_SDATAC      = 4'd7,
    STEP_READ        = 4'd8
  } step_t;

  localparam logic [7:0] CMD_WAKEUP  = 8'h00;
  localparam logic [7:0] CMD_RDATA   = 8'h01;
  localparam logic [7:0] CMD_RDATAC  = 8'h03;
  localparam logic [7:0] CMD_SDATAC  = 8'h0F;
  localparam logic [7:0] CMD_RREG    = 8'h10;
  localparam logic [7:0] CMD_SELFCAL = 8'hF0;
  localparam logic [7:0] CMD_SYNC    = 8'hFC;

  localparam logic [3:0] REG_STATUS  = 4'h0;

  // RREG: first byte carries the register address, second byte is (count - 1)
  localparam logic [23:0] FRAME_NONE        = 24'h000000;
  localparam logic [23:0] FRAME_SELFCAL     = {CMD_SELFCAL, 16'h0000};
  localparam logic [23:0] FRAME_RREG_STATUS = {CMD_RREG | {4'h0, REG_STATUS}, 8'h00, 8'h00};
  localparam logic [23:0] FRAME_SYNC        = {CMD_SYNC, 16'h0000};
  localparam logic [23:0] FRAME_WAKEUP      = {CMD_WAKEUP, 16'h0000};
  localparam logic [23:0] FRAME_RDATA       = {CMD_RDATA, 16'h0000};
  localparam logic [23:0] FRAME_RDATAC      = {CMD_RDATAC, 16'h0000};
  localparam logic [23:0] FRAME_SDATAC      = {CMD_SDATAC, 16'h0000};
  // In RDATAC mode the host simply clocks out the sample with no opcode
  localparam logic [23:0] FRAME_READ        = 24'h000000;

  function automatic logic routine_valid(input routine_t r);
    return (r == ROUTINE_CALIBRATE) || (r == ROUTINE_READBACK) ||
           (r == ROUTINE_SINGLE)    || (r == ROUTINE_CONTINUOUS);
  endfunction

  function automatic logic [23:0] frame_of(input step_t s);
    case (s)
      STEP_SELFCAL:     return FRAME_SELFCAL;
      STEP_RREG_STATUS: return FRAME_RREG_STATUS;
      STEP_SYNC:        return FRAME_SYNC;
      STEP_WAKEUP:      return FRAME_WAKEUP;
      STEP_RDATA:       return FRAME_RDATA;
      STEP_RDATAC:      return FRAME_RDATAC;
      STEP_SDATAC:      return FRAME_SDATAC;
      STEP_READ:        return FRAME_READ;
      default:          return FRAME_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ads1256_controller_fsm.sv
// Routine sequencer FSM. Walks each routine as ISSUE/WAIT command steps and
// reports which command step is active; the top level turns that into a frame.
//   clock_i, reset_i     : clock, async active-high reset
//   start_i, routine_i   : routine request (sampled in IDLE only)
//   transaction_done_i   : SPI engine completion pulse
//   continuous_stop_i    : request to leave continuous mode
//   transaction_start_o  : one-cycle start pulse to the SPI engine
//   step_o               : active command step
//   done_o               : sticky routine-complete flag
module ads1256_controller_fsm
  import spi_types_pkg::*;
(
  input  logic     clock_i,
  input  logic     reset_i,
  input  logic     start_i,
  input  routine_t routine_i,
  input  logic     transaction_done_i,
  input  logic     continuous_stop_i,
  output logic     transaction_start_o,
  output step_t    step_o,
  output logic     done_o
);

  // The first command of every routine is issued from IDLE (Mealy), so only
  // later steps need an explicit ISSUE state.
  typedef enum logic [3:0] {
    IDLE              = 4'd0,
    SELFCAL_WAIT      = 4'd1,
    RREG_WAIT         = 4'd2,
    SYNC_WAIT         = 4'd3,
    WAKEUP_ISSUE      = 4'd4,
    WAKEUP_WAIT       = 4'd5,
    RDATA_ISSUE       = 4'd6,
    RDATA_WAIT        = 4'd7,
    RDATAC_WAIT       = 4'd8,
    CONTINUOUS_RDATAC = 4'd9,
    READ_WAIT         = 4'd10,
    SDATAC_ISSUE      = 4'd11,
    SDATAC_WAIT       = 4'd12
  } state_t;

  state_t   state, state_d;
  routine_t routine_q, routine_d;
  logic     stop_q, stop_d;
  logic     done_q, done_d;
  logic     stop_now;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      routine_q <= ROUTINE_NONE;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      routine_q <= routine_d;
      stop_q    <= stop_d;
      done_q    <= done_d;
    end
  end

  // A stop arriving in the same cycle as a read's completion still counts
  assign stop_now = stop_q || continuous_stop_i;

  always_comb begin
    state_d             = state;
    routine_d           = routine_q;
    stop_d              = stop_q;
    done_d              = done_q;
    transaction_start_o = 1'b0;
    step_o              = STEP_NONE;

    if (continuous_stop_i && (routine_q == ROUTINE_CONTINUOUS) &&
        ((state == RDATAC_WAIT) || (state == CONTINUOUS_RDATAC) || (state == READ_WAIT)))
      stop_d = 1'b1;

    case (state)
      IDLE: begin
        if (start_i) begin
          if (routine_valid(routine_i)) begin
            transaction_start_o = 1'b1;
            routine_d           = routine_i;
            done_d              = 1'b0;
            stop_d              = 1'b0;
            case (routine_i)
              ROUTINE_CALIBRATE: begin step_o = STEP_SELFCAL;     state_d = SELFCAL_WAIT; end
              ROUTINE_READBACK:  begin step_o = STEP_RREG_STATUS; state_d = RREG_WAIT;    end
              ROUTINE_SINGLE:    begin step_o = STEP_SYNC;        state_d = SYNC_WAIT;    end
              default:           begin step_o = STEP_RDATAC;      state_d = RDATAC_WAIT;  end
            endcase
          end else begin
            // Unsupported routine: report completion without touching the bus
            done_d = 1'b1;
          end
        end
      end
      SELFCAL_WAIT: begin
        step_o = STEP_SELFCAL;
        if (transaction_done_i) begin state_d = IDLE; done_d = 1'b1; end
      end
      RREG_WAIT: begin
        step_o = STEP_RREG_STATUS;
        if (transaction_done_i) begin state_d = IDLE; done_d = 1'b1; end
      end
      SYNC_WAIT: begin
        step_o = STEP_SYNC;
        if (transaction_done_i) state_d = WAKEUP_ISSUE;
      end
      WAKEUP_ISSUE: begin
        step_o              = STEP_WAKEUP;
        transaction_start_o = 1'b1;
        state_d             = WAKEUP_WAIT;
      end
      WAKEUP_WAIT: begin
        step_o = STEP_WAKEUP;
        if (transaction_done_i) state_d = RDATA_ISSUE;
      end
      RDATA_ISSUE: begin
        step_o              = STEP_RDATA;
        transaction_start_o = 1'b1;
        state_d             = RDATA_WAIT;
      end
      RDATA_WAIT: begin
        step_o = STEP_RDATA;
        if (transaction_done_i) begin state_d = IDLE; done_d = 1'b1; end
      end
      RDATAC_WAIT: begin
        step_o = STEP_RDATAC;
        if (transaction_done_i) state_d = stop_now ? SDATAC_ISSUE : CONTINUOUS_RDATAC;
      end
      CONTINUOUS_RDATAC: begin
        step_o              = STEP_READ;
        transaction_start_o = 1'b1;
        state_d             = READ_WAIT;
      end
      READ_WAIT: begin
        // The in-flight read always finishes before leaving continuous mode
        step_o = STEP_READ;
        if (transaction_done_i) state_d = stop_now ? SDATAC_ISSUE : CONTINUOUS_RDATAC;
      end
      SDATAC_ISSUE: begin
        step_o              = STEP_SDATAC;
        transaction_start_o = 1'b1;
        state_d             = SDATAC_WAIT;
      end
      SDATAC_WAIT: begin
        step_o = STEP_SDATAC;
        if (transaction_done_i) begin state_d = IDLE; done_d = 1'b1; end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done_o = done_q;

endmodule

// File: rtl/ads1256_system_controller.sv
// ADS1256 system controller top. Runs calibrate / readback / single /
// continuous routines as ordered SPI command transactions.
//   clock_i, reset_i    : clock, async active-high reset
//   start_i, routine_i  : routine request
//   transaction_done_i  : SPI engine completion pulse
//   continuous_stop_i   : leave continuous mode
//   transaction_start_o : start pulse to SPI engine
//   command_o           : 24-bit frame {cmd, arg1, arg2}
//   done_o              : sticky routine-complete flag
module ads1256_system_controller
  import spi_types_pkg::*;
(
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  routine_t    routine_i,
  input  logic        transaction_done_i,
  input  logic        continuous_stop_i,
  output logic        transaction_start_o,
  output logic [23:0] command_o,
  output logic        done_o
);

  step_t step;

  ads1256_controller_fsm FSM (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .start_i             (start_i),
    .routine_i           (routine_i),
    .transaction_done_i  (transaction_done_i),
    .continuous_stop_i   (continuous_stop_i),
    .transaction_start_o (transaction_start_o),
    .step_o              (step),
    .done_o              (done_o)
  );

  assign command_o = frame_of(step);

endmodule

// File: tb/tb_ads1256_system_controller.sv
module tb_ads1256_system_controller;
  import spi_types_pkg::*;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  routine_t    routine_i = ROUTINE_NONE;
  logic        transaction_done_i = 1'b0;
  logic        continuous_stop_i = 1'b0;
  logic        transaction_start_o;
  logic [23:0] command_o;
  logic        done_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] seen[$];

  always #5 clock_i = ~clock_i;

  ads1256_system_controller dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .start_i             (start_i),
    .routine_i           (routine_i),
    .transaction_done_i  (transaction_done_i),
    .continuous_stop_i   (continuous_stop_i),
    .transaction_start_o (transaction_start_o),
    .command_o           (command_o),
    .done_o              (done_o)
  );

  // Log every start pulse with its frame
  always @(negedge clock_i)
    if (reset_i === 1'b0 && transaction_start_o === 1'b1) seen.push_back(command_o);

  task automatic cyc();
    @(posedge clock_i); #1;
  endtask

  // Waits for the next start pulse, checks its frame, checks it holds in WAIT,
  // optionally pulses stop mid-transaction, then acknowledges.
  task automatic expect_txn(input logic [23:0] exp, input string nm, input bit stop);
    int n;
    n = 0;
    @(negedge clock_i);
    while (transaction_start_o !== 1'b1 && n < 20) begin
      @(negedge clock_i);
      n++;
    end
    n_cmp++;
    if (n >= 20) begin
      n_bad++;
      $display("FAIL %s_issue: no transaction_start_o seen, required command %h", nm, exp);
    end else if (command_o !== exp) begin
      n_bad++;
      $display("FAIL %s_issue: command_o=%h required %h", nm, command_o, exp);
    end
    cyc();
    start_i = 1'b0;
    @(negedge clock_i);
    n_cmp++;
    if (transaction_start_o !== 1'b0 || command_o !== exp) begin
      n_bad++;
      $display("FAIL %s_wait: start=%b command_o=%h required start=0 command %h",
               nm, transaction_start_o, command_o, exp);
    end
    if (stop) begin
      cyc(); continuous_stop_i = 1'b1;
      cyc(); continuous_stop_i = 1'b0;
      @(negedge clock_i);
      n_cmp++;
      if (transaction_start_o !== 1'b0 || dut.FSM.state !== 4'd10) begin
        n_bad++;
        $display("FAIL %s_inflight: start=%b state=%0d required start=0 state=10",
                 nm, transaction_start_o, dut.FSM.state);
      end
    end
    cyc(); transaction_done_i = 1'b1;
    cyc(); transaction_done_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    #2;
    n_cmp++;
    if (transaction_start_o !== 1'b0 || command_o !== 24'h000000 || done_o !== 1'b0 ||
        dut.FSM.state !== 4'd0) begin
      n_bad++;
      $display("FAIL reset: start=%b cmd=%h done=%b state=%0d required 0/000000/0/0",
               transaction_start_o, command_o, done_o, dut.FSM.state);
    end
    cyc(); cyc();
    reset_i = 1'b0;
    seen.delete();
  endtask

  task automatic test_calibrate();
    cyc();
    seen.delete();
    start_i = 1'b1; routine_i = ROUTINE_CALIBRATE;
    expect_txn(24'hF00000, "cal", 1'b0);
    @(negedge clock_i);
    n_cmp++;
    if (done_o !== 1'b1 || dut.FSM.state !== 4'd0 || seen.size() != 1) begin
      n_bad++;
      $display("FAIL cal_done: done=%b state=%0d pulses=%0d required 1/0/1",
               done_o, dut.FSM.state, seen.size());
    end
  endtask

  task automatic test_single();
    cyc();
    seen.delete();
    start_i = 1'b1; routine_i = ROUTINE_SINGLE;
    expect_txn(24'hFC0000, "sync", 1'b0);
    expect_txn(24'h000000, "wakeup", 1'b0);
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL single_midway_done: done=%b required 0", done_o);
    end
    expect_txn(24'h010000, "rdata", 1'b0);
    @(negedge clock_i);
    n_cmp++;
    if (done_o !== 1'b1 || seen.size() != 3) begin
      n_bad++;
      $display("FAIL single_done: done=%b pulses=%0d required 1/3", done_o, seen.size());
    end else begin
      n_cmp++;
      if (seen[0] !== 24'hFC0000 || seen[1] !== 24'h000000 || seen[2] !== 24'h010000) begin
        n_bad++;
        $display("FAIL single_order: %h %h %h required FC0000 000000 010000",
                 seen[0], seen[1], seen[2]);
      end
    end
  endtask

  task automatic test_readback();
    cyc();
    seen.delete();
    start_i = 1'b1; routine_i = ROUTINE_READBACK;
    expect_txn(24'h100000, "rreg", 1'b0);
    @(negedge clock_i);
    n_cmp++;
    if (done_o !== 1'b1 || seen.size() != 1) begin
      n_bad++;
      $display("FAIL rreg_done: done=%b pulses=%0d required 1/1", done_o, seen.size());
    end
    // A fresh accepted start clears the sticky flag
    cyc();
    start_i = 1'b1; routine_i = ROUTINE_CALIBRATE;
    cyc();
    start_i = 1'b0;
    @(negedge clock_i);
    n_cmp++;
    if (done_o !== 1'b0 || dut.FSM.state !== 4'd1) begin
      n_bad++;
      $display("FAIL restart_clear: done=%b state=%0d required 0/1", done_o, dut.FSM.state);
    end
    cyc(); transaction_done_i = 1'b1;
    cyc(); transaction_done_i = 1'b0;
    @(negedge clock_i);
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_done: done=%b required 1", done_o);
    end
  endtask

  task automatic test_ignore_start();
    cyc();
    seen.delete();
    start_i = 1'b1; routine_i = ROUTINE_CALIBRATE;
    cyc();
    routine_i = ROUTINE_READBACK;  // start_i stays high while busy
    repeat (3) @(negedge clock_i);
    n_cmp++;
    if (transaction_start_o !== 1'b0 || command_o !== 24'hF00000 || dut.FSM.state !== 4'd1) begin
      n_bad++;
      $display("FAIL busy_start: start=%b cmd=%h state=%0d required 0/F00000/1",
               transaction_start_o, command_o, dut.FSM.state);
    end
    start_i = 1'b0;
    cyc(); transaction_done_i = 1'b1;
    cyc(); transaction_done_i = 1'b0;
    @(negedge clock_i);
    n_cmp++;
    if (done_o !== 1'b1 || seen.size() != 1) begin
      n_bad++;
      $display("FAIL busy_done: done=%b pulses=%0d required 1/1", done_o, seen.size());
    end
  endtask

  task automatic test_continuous();
    cyc();
    seen.delete();
    start_i = 1'b1; routine_i = ROUTINE_CONTINUOUS;
    expect_txn(24'h030000, "rdatac", 1'b0);
    #1;
    n_cmp++;
    if (dut.FSM.state !== 4'd9 || transaction_start_o !== 1'b1 || command_o !== 24'h000000) begin
      n_bad++;
      $display("FAIL cont_enter: state=%0d start=%b cmd=%h required 9/1/000000",
               dut.FSM.state, transaction_start_o, command_o);
    end
    expect_txn(24'h000000, "read1", 1'b0);
    expect_txn(24'h000000, "read2", 1'b1);
    expect_txn(24'h0F0000, "sdatac", 1'b0);
    @(negedge clock_i);
    n_cmp++;
    if (done_o !== 1'b1 || dut.FSM.state !== 4'd0 || seen.size() != 4) begin
      n_bad++;
      $display("FAIL cont_done: done=%b state=%0d pulses=%0d required 1/0/4",
               done_o, dut.FSM.state, seen.size());
    end
  endtask

  task automatic test_illegal();
    routine_t bad[2];
    bad[0] = ROUTINE_ILLEGAL;
    bad[1] = ROUTINE_NONE;
    for (int i = 0; i < 2; i++) begin
      cyc(); reset_i = 1'b1;
      cyc(); reset_i = 1'b0;
      seen.delete();
      start_i = 1'b1; routine_i = bad[i];
      @(negedge clock_i);
      n_cmp++;
      if (transaction_start_o !== 1'b0 || command_o !== 24'h000000 || done_o !== 1'b0) begin
        n_bad++;
        $display("FAIL bad_issue[%0d]: start=%b cmd=%h done=%b required 0/000000/0",
                 i, transaction_start_o, command_o, done_o);
      end
      cyc(); start_i = 1'b0;
      @(negedge clock_i);
      n_cmp++;
      if (done_o !== 1'b1 || dut.FSM.state !== 4'd0) begin
        n_bad++;
        $display("FAIL bad_done[%0d]: done=%b state=%0d required 1/0", i, done_o, dut.FSM.state);
      end
      // A stray completion in IDLE does nothing
      cyc(); transaction_done_i = 1'b1;
      cyc(); transaction_done_i = 1'b0;
      repeat (3) cyc();
      @(negedge clock_i);
      n_cmp++;
      if (seen.size() != 0 || dut.FSM.state !== 4'd0 || done_o !== 1'b1) begin
        n_bad++;
        $display("FAIL bad_quiet[%0d]: pulses=%0d state=%0d done=%b required 0/0/1",
                 i, seen.size(), dut.FSM.state, done_o);
      end
    end
  endtask

  task automatic test_reset_mid_single();
    cyc();
    seen.delete();
    start_i = 1'b1; routine_i = ROUTINE_SINGLE;
    expect_txn(24'hFC0000, "rst_sync", 1'b0);
    @(negedge clock_i);
    n_cmp++;
    if (transaction_start_o !== 1'b1 || command_o !== 24'h000000 || dut.FSM.state !== 4'd4) begin
      n_bad++;
      $display("FAIL wakeup_issue: start=%b cmd=%h state=%0d required 1/000000/4",
               transaction_start_o, command_o, dut.FSM.state);
    end
    @(negedge clock_i);
    n_cmp++;
    if (dut.FSM.state !== 4'd5) begin
      n_bad++;
      $display("FAIL wakeup_wait: state=%0d required 5", dut.FSM.state);
    end
    #1 reset_i = 1'b1;
    #1;
    n_cmp++;
    if (dut.FSM.state !== 4'd0 || done_o !== 1'b0 || transaction_start_o !== 1'b0 ||
        command_o !== 24'h000000) begin
      n_bad++;
      $display("FAIL mid_reset: state=%0d done=%b start=%b cmd=%h required 0/0/0/000000",
               dut.FSM.state, done_o, transaction_start_o, command_o);
    end
    cyc(); cyc();
    reset_i = 1'b0;
    seen.delete();
    repeat (5) cyc();
    n_cmp++;
    if (seen.size() != 0) begin
      n_bad++;
      $display("FAIL post_reset_quiet: pulses=%0d required 0", seen.size());
    end
    start_i = 1'b1; routine_i = ROUTINE_CALIBRATE;
    expect_txn(24'hF00000, "post_cal", 1'b0);
    @(negedge clock_i);
    n_cmp++;
    if (done_o !== 1'b1 || seen.size() != 1) begin
      n_bad++;
      $display("FAIL post_cal_done: done=%b pulses=%0d required 1/1", done_o, seen.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_calibrate();
    test_single();
    test_readback();
    test_ignore_start();
    test_continuous();
    test_illegal();
    test_reset_mid_single();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ads1256_system_controller.md
Name: ads1256_system_controller

Overview:
Top-level command sequencer for the ADS1256 ADC front end. On a start request it runs a selected routine (calibrate, register readback, single conversion, continuous conversion) as an ordered series of SPI command transactions. Each command is presented on command_o and handed to the SPI transaction engine with a start/done handshake. It sits between the system/host control logic and the SPI transaction layer.

Parameters:
None. All command codes are fixed constants in spi_types_pkg.

Ports:
clock_i  input  1  system clock, all state on rising edge
reset_i  input  1  asynchronous, active-high reset
start_i  input  1  routine start request, sampled only in IDLE
routine_i  input  routine_t  routine select, sampled with start_i
transaction_done_i  input  1  one-cycle pulse from SPI engine: current transaction finished
continuous_stop_i  input  1  request to leave continuous mode (level or pulse)
transaction_start_o  output  1  one-cycle pulse: SPI engine must begin transaction with command_o
command_o  output  24  frame {cmd byte[23:16], arg1[15:8], arg2[7:0]}
done_o  output  1  routine complete flag (sticky)

Behaviour:
- Reset (async): state=IDLE, latched routine=ROUTINE_NONE, stop flag=0, done_o=0. Outputs combinational from state: transaction_start_o=0, command_o=24'h000000.
- Command frames: SELFCAL=F00000, RREG STATUS (1 reg)=100000, SYNC=FC0000, WAKEUP=000000, RDATA=010000, RDATAC=030000, SDATAC=0F0000, continuous read frame=000000.
- IDLE: if start_i=1 and routine_i is valid (CALIBRATE, READBACK, SINGLE, CONTINUOUS), then in the same cycle (Mealy) transaction_start_o=1 and command_o=first command of routine_i. Routine is latched, done_o clears, and the FSM moves to that command's WAIT state.
- If start_i=1 with ROUTINE_NONE or ROUTINE_ILLEGAL: no transaction is issued; done_o sets next cycle and the FSM stays in IDLE.
- Every command step uses ISSUE (1 cycle, transaction_start_o=1) then WAIT (transaction_start_o=0). command_o holds the step's frame through both. WAIT advances only on transaction_done_i=1.
- CALIBRATE: SELFCAL -> complete.
- READBACK: RREG STATUS -> complete.
- SINGLE: SYNC -> WAKEUP -> RDATA -> complete.
- CONTINUOUS: RDATAC -> CONTINUOUS_RDATAC.
  - CONTINUOUS_RDATAC repeatedly issues read frames (000000), one ISSUE/WAIT per sample.
  - continuous_stop_i=1 in any continuous state sets a stop flag.
  - When a read's transaction_done_i arrives with the stop flag set (or stop already set on entry), go to SDATAC ISSUE/WAIT -> complete. An in-flight transaction is never aborted.
- Complete: on the final transaction_done_i, return to IDLE and set done_o. done_o holds until the next accepted start_i or reset.
- transaction_done_i in IDLE or ISSUE is ignored.
- start_i outside IDLE is ignored.
- Reset mid-routine aborts immediately to IDLE with no further transaction_start_o.
- State register is 4 bits; IDLE encodes as 4'd0.

Decomposition:
- spi_types_pkg:
  - routine_t enum (3-bit): ROUTINE_NONE=0, CALIBRATE, READBACK, SINGLE, CONTINUOUS, ILLEGAL.
  - ADS1256 command byte constants.
  - 24-bit frame constants.
- One sub-module, ads1256_controller_fsm, instantiated as instance FSM. It holds `state` (4-bit, IDLE=0) and the state constants, including one named CONTINUOUS_RDATAC. Top level wires ports through and decodes command_o.

Test Plan:
- Calibrate: reset, start_i=1 with CALIBRATE -> same cycle transaction_start_o=1, command_o=F00000; after transaction_done_i pulse -> done_o=1, state=0.
- Single: start SINGLE; ack each transaction -> exactly 3 start pulses, with commands FC0000, 000000, 010000 in order; done_o=1 after third ack.
- Readback: start READBACK -> command 100000, one start pulse; done_o=1 after ack. A new start clears done_o.
- Continuous: start CONTINUOUS; ack RDATAC -> state=CONTINUOUS_RDATAC with repeated 000000 start pulses. Assert continuous_stop_i mid-read -> current read completes, then 0F0000 issued; ack -> done_o=1.
- Illegal: start ILLEGAL -> no transaction_start_o ever; done_o=1 next cycle; state stays 0.
- Reset mid-SINGLE (in WAKEUP WAIT) -> state=0, done_o=0, no start pulses; a subsequent CALIBRATE runs normally.
